// File: rtl/risc16_pkg.sv
// Shared RiSC-16 constants: datapath defaults, opcode encodings and the issue FSM states.
package risc16_pkg;

  localparam int unsigned WordLenDefault = 16;
  localparam int unsigned RegAddrDefault = 3;

  localparam logic [2:0] OpcAdd  = 3'd0;
  localparam logic [2:0] OpcAddi = 3'd1;
  localparam logic [2:0] OpcNand = 3'd2;
  localparam logic [2:0] OpcLui  = 3'd3;
  localparam logic [2:0] OpcSw   = 3'd4;
  localparam logic [2:0] OpcLw   = 3'd5;
  localparam logic [2:0] OpcBeq  = 3'd6;
  localparam logic [2:0] OpcJalr = 3'd7;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StBubble = 1'b1
  } issue_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: r0 reads zero, then EX/MEM, then MEM/WB, then the regfile.
module fwd_mux #(
  parameter int unsigned p_WORD_LEN = 16,
  parameter int unsigned p_REG_ADDR = 3
) (
  input  logic [p_REG_ADDR-1:0] i_addr,
  input  logic [p_WORD_LEN-1:0] i_regval,
  input  logic                  i_fwd1_valid,
  input  logic [p_REG_ADDR-1:0] i_fwd1_addr,
  input  logic [p_WORD_LEN-1:0] i_fwd1_data,
  input  logic                  i_fwd2_valid,
  input  logic [p_REG_ADDR-1:0] i_fwd2_addr,
  input  logic [p_WORD_LEN-1:0] i_fwd2_data,
  output logic [p_WORD_LEN-1:0] o_value
);

  // Younger writer (fwd1) wins over older writer (fwd2).
  always_comb begin
    o_value = i_regval;
    if (i_addr == '0) begin
      o_value = '0;
    end else if (i_fwd1_valid && (i_fwd1_addr == i_addr)) begin
      o_value = i_fwd1_data;
    end else if (i_fwd2_valid && (i_fwd2_addr == i_addr)) begin
      o_value = i_fwd2_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: operand forwarding, ALU drive, EX/MEM slot and branch redirect.
module alu_issue
  import risc16_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = WordLenDefault,
  parameter int unsigned p_REG_ADDR = RegAddrDefault
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  output logic                  o_id_ready,
  input  logic [2:0]            i_id_opc,
  input  logic [p_REG_ADDR-1:0] i_id_rega_addr,
  input  logic [p_REG_ADDR-1:0] i_id_regb_addr,
  input  logic [p_WORD_LEN-1:0] i_id_rega,
  input  logic [p_WORD_LEN-1:0] i_id_regb,
  input  logic [p_WORD_LEN-1:0] i_id_imm,
  input  logic [p_REG_ADDR-1:0] i_id_tgt,
  input  logic [p_WORD_LEN-1:0] i_id_pc,
  input  logic                  i_fwd1_valid,
  input  logic [p_REG_ADDR-1:0] i_fwd1_addr,
  input  logic [p_WORD_LEN-1:0] i_fwd1_data,
  input  logic                  i_fwd1_is_load,
  input  logic                  i_fwd2_valid,
  input  logic [p_REG_ADDR-1:0] i_fwd2_addr,
  input  logic [p_WORD_LEN-1:0] i_fwd2_data,
  output logic                  o_alu_op,
  output logic [p_WORD_LEN-1:0] o_alu_ina,
  output logic [p_WORD_LEN-1:0] o_alu_inb,
  input  logic [p_WORD_LEN-1:0] i_alu_out,
  input  logic                  i_alu_eq,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output logic [2:0]            o_ex_opc,
  output logic [p_REG_ADDR-1:0] o_ex_tgt,
  output logic [p_WORD_LEN-1:0] o_ex_result,
  output logic [p_WORD_LEN-1:0] o_ex_store_data,
  output logic                  o_redirect,
  output logic [p_WORD_LEN-1:0] o_redirect_pc,
  input  logic                  i_flush
);

  issue_state_e          state_q;
  logic                  ex_valid_q;
  logic [2:0]            ex_opc_q;
  logic [p_REG_ADDR-1:0] ex_tgt_q;
  logic [p_WORD_LEN-1:0] ex_result_q;
  logic [p_WORD_LEN-1:0] ex_store_q;
  logic                  redirect_q;
  logic [p_WORD_LEN-1:0] redirect_pc_q;

  logic [p_WORD_LEN-1:0] opnd_a;
  logic [p_WORD_LEN-1:0] opnd_b;
  logic                  use_a;
  logic                  use_b;
  logic                  hazard;
  logic                  slot_free;
  logic                  transfer;
  logic                  taken;
  logic [p_WORD_LEN-1:0] target;
  logic [p_WORD_LEN-1:0] pc_inc;
  logic [p_WORD_LEN-1:0] result;

  fwd_mux #(.p_WORD_LEN(p_WORD_LEN), .p_REG_ADDR(p_REG_ADDR)) u_fwd_a (
    .i_addr      (i_id_rega_addr),
    .i_regval    (i_id_rega),
    .i_fwd1_valid(i_fwd1_valid),
    .i_fwd1_addr (i_fwd1_addr),
    .i_fwd1_data (i_fwd1_data),
    .i_fwd2_valid(i_fwd2_valid),
    .i_fwd2_addr (i_fwd2_addr),
    .i_fwd2_data (i_fwd2_data),
    .o_value     (opnd_a)
  );

  fwd_mux #(.p_WORD_LEN(p_WORD_LEN), .p_REG_ADDR(p_REG_ADDR)) u_fwd_b (
    .i_addr      (i_id_regb_addr),
    .i_regval    (i_id_regb),
    .i_fwd1_valid(i_fwd1_valid),
    .i_fwd1_addr (i_fwd1_addr),
    .i_fwd1_data (i_fwd1_data),
    .i_fwd2_valid(i_fwd2_valid),
    .i_fwd2_addr (i_fwd2_addr),
    .i_fwd2_data (i_fwd2_data),
    .o_value     (opnd_b)
  );

  // Decode which operands are read and how they map onto the ALU ports.
  always_comb begin
    use_a     = 1'b0;
    use_b     = 1'b0;
    o_alu_op  = 1'b0;
    o_alu_ina = '0;
    o_alu_inb = '0;
    unique case (i_id_opc)
      OpcAdd, OpcBeq: begin
        use_a = 1'b1; use_b = 1'b1; o_alu_ina = opnd_a; o_alu_inb = opnd_b;
      end
      OpcNand: begin
        use_a = 1'b1; use_b = 1'b1; o_alu_op = 1'b1; o_alu_ina = opnd_a; o_alu_inb = opnd_b;
      end
      OpcAddi, OpcLw: begin
        use_b = 1'b1; o_alu_ina = opnd_b; o_alu_inb = i_id_imm;
      end
      // SW reads regA as store data in addition to the regB address base.
      OpcSw: begin
        use_a = 1'b1; use_b = 1'b1; o_alu_ina = opnd_b; o_alu_inb = i_id_imm;
      end
      OpcLui: begin
        o_alu_inb = i_id_imm;
      end
      OpcJalr: begin
        use_b = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake, load-use detection and result/redirect selection.
  always_comb begin
    hazard = (state_q == StRun) && i_id_valid && i_fwd1_valid && i_fwd1_is_load &&
             (i_fwd1_addr != '0) &&
             ((use_a && (i_id_rega_addr == i_fwd1_addr)) ||
              (use_b && (i_id_regb_addr == i_fwd1_addr)));
    slot_free  = !ex_valid_q || i_ex_ready;
    o_id_ready = (state_q == StRun) && !hazard && slot_free;
    transfer   = i_id_valid && o_id_ready;
    pc_inc     = i_id_pc + p_WORD_LEN'(1);
    result     = (i_id_opc == OpcJalr) ? pc_inc : i_alu_out;
    taken      = (i_id_opc == OpcJalr) || ((i_id_opc == OpcBeq) && i_alu_eq);
    target     = (i_id_opc == OpcJalr) ? opnd_b : (pc_inc + i_id_imm);
  end

  // Issue FSM, EX/MEM slot and one-cycle redirect pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StRun;
      ex_valid_q    <= 1'b0;
      ex_opc_q      <= '0;
      ex_tgt_q      <= '0;
      ex_result_q   <= '0;
      ex_store_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else if (i_flush) begin
      state_q    <= StRun;
      ex_valid_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= transfer && taken;
      if (transfer && taken) begin
        redirect_pc_q <= target;
      end
      unique case (state_q)
        StRun:    if (hazard && slot_free) state_q <= StBubble;
        StBubble: state_q <= StRun;
        default:  state_q <= StRun;
      endcase
      // A free slot takes the accepted instruction, or a bubble when nothing transfers.
      if (slot_free) begin
        ex_valid_q <= transfer;
        if (transfer) begin
          ex_opc_q    <= i_id_opc;
          ex_tgt_q    <= i_id_tgt;
          ex_result_q <= result;
          ex_store_q  <= opnd_a;
        end
      end
    end
  end

  assign o_ex_valid      = ex_valid_q;
  assign o_ex_opc        = ex_opc_q;
  assign o_ex_tgt        = ex_tgt_q;
  assign o_ex_result     = ex_result_q;
  assign o_ex_store_data = ex_store_q;
  assign o_redirect      = redirect_q;
  assign o_redirect_pc   = redirect_pc_q;

endmodule
